// File: rtl/jtframe_pocket_dwnld.sv
// jtframe_pocket_dwnld
// Converts Pocket APF bridge ROM download writes (32-bit, big-endian) into the
// ioctl stream consumed by the jtframe download path. Bridge data words are
// queued in a small FIFO. A serialiser then emits them MSB first as IOCTLW-wide
// ioctl writes. The writes are paced by WR_GAP and stalled by ioctl_hold.
// A control/status register at CTRL_ADDR starts and ends a download session.
// Optional build macro: JTFRAME_POCKET_CHKSUM_EN. When it is defined, a 16-bit
// running byte checksum is readable at CTRL_ADDR+4.
module jtframe_pocket_dwnld #(
    parameter int          IOCTLW    = 8,
    parameter int          FIFO_AW   = 4,
    parameter logic [31:0] CTRL_ADDR = 32'hF800_0000,
    parameter logic [31:0] DATA_BASE = 32'h0000_0000,
    parameter logic [31:0] DATA_MASK = 32'hF000_0000,
    parameter int          WR_GAP    = 3
)(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       bridge_addr,
    input  logic              bridge_wr,
    input  logic [31:0]       bridge_wr_data,
    input  logic              bridge_rd,
    output logic [31:0]       bridge_rd_data,
    output logic [24:0]       ioctl_addr,
    output logic [IOCTLW-1:0] ioctl_dout,
    output logic              ioctl_wr,
    input  logic              ioctl_hold,
    output logic              downloading
);

    localparam int          DEPTH      = 1 << FIFO_AW;
    localparam int          NBEAT      = 32 / IOCTLW;
    localparam int          BSTEP      = IOCTLW / 8;
    localparam int          QW         = 57;
    localparam logic [2:0]  NBEAT_L    = 3'(NBEAT);
    localparam logic [24:0] BSTEP_L    = 25'(BSTEP);
    localparam logic [3:0]  GAP_RELOAD = (WR_GAP > 0) ? 4'(WR_GAP - 1) : 4'd0;
    localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW + 1)'(DEPTH);
`ifdef JTFRAME_POCKET_CHKSUM_EN
    localparam logic [31:0] CHK_ADDR   = CTRL_ADDR + 32'd4;
`endif

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t state_r, state_nx_s;

    // Bridge address decode and control-register commands
    logic ctrl_hit_s, data_hit_s, ctrl_wr_s, start_req_s, end_req_s, start_acc_s;

    assign ctrl_hit_s  = (bridge_addr == CTRL_ADDR);
    assign data_hit_s  = ((bridge_addr & DATA_MASK) == DATA_BASE) && !ctrl_hit_s;
    assign ctrl_wr_s   = bridge_wr && ctrl_hit_s;
    // start wins over end when both bits are written together
    assign start_req_s = ctrl_wr_s && bridge_wr_data[0];
    assign end_req_s   = ctrl_wr_s && bridge_wr_data[1] && !bridge_wr_data[0];
    assign start_acc_s = start_req_s && (state_r == ST_IDLE);

    // FIFO storage and bookkeeping
    logic [QW-1:0]      mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   level_r;
    logic               fifo_empty_s, fifo_full_s, push_req_s, push_s, pop_s;
    logic [QW-1:0]      fifo_q_s;
    logic               overflow_r;

    assign fifo_empty_s = (level_r == {(FIFO_AW + 1){1'b0}});
    assign fifo_full_s  = (level_r == DEPTH_L);
    assign push_req_s   = bridge_wr && data_hit_s && (state_r == ST_ACTIVE);
    // fullness comes from the registered level, so a same-cycle pop never rescues a push
    assign push_s       = push_req_s && !fifo_full_s;
    assign fifo_q_s     = mem_r[rd_ptr_r];

    // Serialiser state
    logic [31:0] word_r;
    logic [24:0] base_r;
    logic [2:0]  left_r;
    logic [2:0]  idx_r;
    logic        beat_valid_r;
    logic [3:0]  gap_r;
    logic        ser_idle_s, consume_s, stage_s;
    logic [24:0] beat_off_s;

    assign ser_idle_s = (left_r == 3'd0) && !beat_valid_r;
    // a pending beat is only taken when downstream is not holding
    assign consume_s  = beat_valid_r && !ioctl_hold;
    // new words are not fetched while downstream holds, so queued words stay in the FIFO
    assign pop_s      = ser_idle_s && !fifo_empty_s && !ioctl_hold;
    // stage the next beat once the gap has elapsed; with no gap, restage as the previous beat is consumed
    assign stage_s    = (left_r != 3'd0) && !ioctl_hold &&
                        (beat_valid_r ? (consume_s && (WR_GAP == 0)) : (gap_r == 4'd0));
    assign beat_off_s = {22'd0, idx_r} * BSTEP_L;

    // the pulse is gated by hold so ioctl_wr can never coincide with ioctl_hold
    assign ioctl_wr = beat_valid_r && !ioctl_hold;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_req_s) state_nx_s = ST_ACTIVE;
                else             state_nx_s = ST_IDLE;
            end
            ST_ACTIVE: begin
                if (end_req_s) state_nx_s = ST_DRAIN;
                else           state_nx_s = ST_ACTIVE;
            end
            ST_DRAIN: begin
                if (fifo_empty_s && ser_idle_s) state_nx_s = ST_IDLE;
                else                            state_nx_s = ST_DRAIN;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM outputs: session flag derived from the state register
    always_comb begin
        downloading = 1'b0;
        case (state_r)
            ST_IDLE:   downloading = 1'b0;
            ST_ACTIVE: downloading = 1'b1;
            ST_DRAIN:  downloading = 1'b1;
            default:   downloading = 1'b0;
        endcase
    end

    // FIFO data array, written on accepted pushes (contents are don't-care when empty)
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= {bridge_addr[24:0], bridge_wr_data};
        end
    end

    // FIFO pointers and fill level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            level_r  <= {(FIFO_AW + 1){1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + {{(FIFO_AW - 1){1'b0}}, 1'b1};
            if (pop_s)  rd_ptr_r <= rd_ptr_r + {{(FIFO_AW - 1){1'b0}}, 1'b1};
            case ({push_s, pop_s})
                2'b10:   level_r <= level_r + {{FIFO_AW{1'b0}}, 1'b1};
                2'b01:   level_r <= level_r - {{FIFO_AW{1'b0}}, 1'b1};
                default: level_r <= level_r;
            endcase
        end
    end

    // Sticky overflow flag: set on a push into a full FIFO, cleared by start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (start_acc_s) begin
            overflow_r <= 1'b0;
        end else if (push_req_s && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Serialiser: load a word, then stage its beats MSB first with gap pacing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_r       <= 32'd0;
            base_r       <= 25'd0;
            left_r       <= 3'd0;
            idx_r        <= 3'd0;
            beat_valid_r <= 1'b0;
            gap_r        <= 4'd0;
            ioctl_addr   <= 25'd0;
            ioctl_dout   <= {IOCTLW{1'b0}};
        end else begin
            if (pop_s) begin
                word_r <= fifo_q_s[31:0];
                base_r <= fifo_q_s[56:32];
                left_r <= NBEAT_L;
                idx_r  <= 3'd0;
            end else if (stage_s) begin
                word_r     <= word_r << IOCTLW;
                left_r     <= left_r - 3'd1;
                idx_r      <= idx_r + 3'd1;
                ioctl_dout <= word_r[31 -: IOCTLW];
                ioctl_addr <= base_r + beat_off_s;
            end else begin
                word_r <= word_r;
            end

            if (stage_s)        beat_valid_r <= 1'b1;
            else if (consume_s) beat_valid_r <= 1'b0;
            else                beat_valid_r <= beat_valid_r;

            // gap counts from the pulse and freezes while downstream holds
            if (consume_s)                           gap_r <= GAP_RELOAD;
            else if (!ioctl_hold && gap_r != 4'd0)   gap_r <= gap_r - 4'd1;
            else                                     gap_r <= gap_r;
        end
    end

`ifdef JTFRAME_POCKET_CHKSUM_EN
    logic [15:0] sum_r;

    function automatic logic [15:0] byte_sum(input logic [IOCTLW-1:0] d);
        logic [15:0] acc;
        acc = 16'd0;
        for (int i = 0; i < BSTEP; i++) begin
            acc = acc + {8'd0, d[i*8 +: 8]};
        end
        return acc;
    endfunction

    // Running modulo-2^16 sum of every emitted byte, cleared by start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r <= 16'd0;
        end else if (start_acc_s) begin
            sum_r <= 16'd0;
        end else if (ioctl_wr) begin
            sum_r <= sum_r + byte_sum(ioctl_dout);
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    // Status word layout
    logic [31:0] status_s;
    logic [31:0] rd_mux_s;

    // Assemble the status register from live flags and the FIFO level
    always_comb begin
        status_s                 = 32'd0;
        status_s[0]              = downloading;
        status_s[1]              = overflow_r;
        status_s[2]              = fifo_empty_s;
        status_s[FIFO_AW+8:8]    = level_r;
    end

    // Read-data select for the addressed register
    always_comb begin
        rd_mux_s = 32'd0;
        if (ctrl_hit_s) begin
            rd_mux_s = status_s;
        end
`ifdef JTFRAME_POCKET_CHKSUM_EN
        else if (bridge_addr == CHK_ADDR) begin
            rd_mux_s = {16'd0, sum_r};
        end
`endif
        else begin
            rd_mux_s = 32'd0;
        end
    end

    // Read data is captured one cycle after the strobe and held until the next read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bridge_rd_data <= 32'd0;
        end else if (bridge_rd) begin
            bridge_rd_data <= rd_mux_s;
        end else begin
            bridge_rd_data <= bridge_rd_data;
        end
    end

endmodule

// File: tb/tb_jtframe_pocket_dwnld.sv
// Directed self-checking bench for jtframe_pocket_dwnld: an 8-bit instance
// exercises sessions, pacing, hold, overflow and drain; a 16-bit instance
// checks the two-beat word split. Expected ioctl beats go into scoreboard
// queues and are compared by per-instance monitors.
module tb_jtframe_pocket_dwnld;

    localparam logic [31:0] CTRL = 32'hF800_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] bridge_addr, bridge_wr_data;
    logic        wr8, wr16, bridge_rd;
    logic        hold8, hold16;
    logic [31:0] rd8, rd16;
    logic [24:0] ioctl_addr8, ioctl_addr16;
    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic        iwr8, iwr16, dl8, dl16;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int fall_cyc = -1;
    logic dl_prev = 1'b0;

    logic [40:0] q8[$];
    logic [40:0] q16[$];
    int          pt8[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    jtframe_pocket_dwnld #(.IOCTLW(8)) dut (
        .clk(clk), .rst(rst), .bridge_addr(bridge_addr), .bridge_wr(wr8),
        .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd), .bridge_rd_data(rd8),
        .ioctl_addr(ioctl_addr8), .ioctl_dout(dout8), .ioctl_wr(iwr8),
        .ioctl_hold(hold8), .downloading(dl8)
    );

    jtframe_pocket_dwnld #(.IOCTLW(16)) dut16 (
        .clk(clk), .rst(rst), .bridge_addr(bridge_addr), .bridge_wr(wr16),
        .bridge_wr_data(bridge_wr_data), .bridge_rd(bridge_rd), .bridge_rd_data(rd16),
        .ioctl_addr(ioctl_addr16), .ioctl_dout(dout16), .ioctl_wr(iwr16),
        .ioctl_hold(hold16), .downloading(dl16)
    );

    // 8-bit monitor: hold rule, beat scoreboard, pulse times, session fall time
    always @(negedge clk) begin
        logic [40:0] e;
        if (hold8 === 1'b1) begin
            tests++;
            assert (iwr8 === 1'b0) else begin
                fails++; $error("FAIL wr_during_hold: observed %b expected 0", iwr8);
            end
        end
        if (iwr8 === 1'b1) begin
            pt8.push_back(cyc);
            tests++;
            assert (q8.size() != 0) else begin
                fails++; $error("FAIL beat8_unexpected: observed addr %h data %h expected none", ioctl_addr8, dout8);
            end
            if (q8.size() != 0) begin
                e = q8.pop_front();
                tests++;
                assert ({ioctl_addr8, 8'h00, dout8} === e) else begin
                    fails++; $error("FAIL beat8: observed %h expected %h", {ioctl_addr8, 8'h00, dout8}, e);
                end
            end
        end
        if (dl_prev && !dl8) fall_cyc = cyc;
        dl_prev = dl8;
    end

    // 16-bit monitor: beat scoreboard
    always @(negedge clk) begin
        logic [40:0] e;
        if (iwr16 === 1'b1) begin
            tests++;
            assert (q16.size() != 0) else begin
                fails++; $error("FAIL beat16_unexpected: observed addr %h data %h expected none", ioctl_addr16, dout16);
            end
            if (q16.size() != 0) begin
                e = q16.pop_front();
                tests++;
                assert ({ioctl_addr16, dout16} === e) else begin
                    fails++; $error("FAIL beat16: observed %h expected %h", {ioctl_addr16, dout16}, e);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++; $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input bit sel16);
        bridge_addr    = a;
        bridge_wr_data = d;
        if (sel16) wr16 = 1'b1;
        else       wr8  = 1'b1;
        tick(1);
        wr8  = 1'b0;
        wr16 = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d8, output logic [31:0] d16);
        bridge_addr = a;
        bridge_rd   = 1'b1;
        tick(1);
        bridge_rd = 1'b0;
        d8  = rd8;
        d16 = rd16;
    endtask

    task automatic push8(input logic [31:0] a, input logic [31:0] d);
        for (int k = 0; k < 4; k++) begin
            q8.push_back({25'(a + 32'(k)), 8'h00, d[31 - 8*k -: 8]});
        end
    endtask

    task automatic wait_q8(input int budget, input string tag);
        int n = 0;
        while (q8.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check(tag, 32'(q8.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] r8, r16, d;
        int n;
        rst = 1'b1;
        bridge_addr = 32'd0; bridge_wr_data = 32'd0;
        wr8 = 1'b0; wr16 = 1'b0; bridge_rd = 1'b0;
        hold8 = 1'b0; hold16 = 1'b0;
        tick(3);
        check("rst_wr", {31'd0, iwr8}, 32'd0);
        check("rst_dl", {31'd0, dl8}, 32'd0);
        check("rst_addr", {7'd0, ioctl_addr8}, 32'd0);
        check("rst_rd", rd8, 32'd0);
        rst = 1'b0;
        tick(2);

        // idle status and read-data hold
        bus_read(CTRL, r8, r16);
        check("status_reset", r8, 32'h0000_0004);
        tick(3);
        check("rd_hold", rd8, 32'h0000_0004);
        bus_read(32'h1234_0000, r8, r16);
        check("rd_other", r8, 32'd0);

        // data writes are ignored while idle
        bus_write(32'h0000_0040, 32'hCAFE_BABE, 1'b0);
        tick(10);
        bus_read(CTRL, r8, r16);
        check("idle_ignore", r8, 32'h0000_0004);

        // start, one word, latency and pacing
        bus_write(CTRL, 32'h1, 1'b0);
        bus_read(CTRL, r8, r16);
        check("start_status", r8, 32'h0000_0005);
        pt8.delete();
        push8(32'h10, 32'h1122_3344);
        n = cyc;
        bus_write(32'h10, 32'h1122_3344, 1'b0);
        wait_q8(100, "word1_done");
        check("pulses1", 32'(pt8.size()), 32'd4);
        check("latency", 32'(pt8[0] - n), 32'd3);
        for (int i = 0; i < 3; i++) check("gap1", 32'(pt8[i+1] - pt8[i]), 32'd4);

        // 16-bit instance: two beats per word
        q16.push_back({25'h10, 16'h1122});
        q16.push_back({25'h12, 16'h3344});
        bus_write(CTRL, 32'h1, 1'b1);
        bus_write(32'h10, 32'h1122_3344, 1'b1);
        n = 0;
        while (q16.size() != 0 && n < 100) begin tick(1); n++; end
        check("word16_done", 32'(q16.size()), 32'd0);
        check("dl16", {31'd0, dl16}, 32'd1);
        bus_read(CTRL, r8, r16);
        check("status16", r16, 32'h0000_0005);
        check("status8_active", r8, 32'h0000_0005);

        // overflow: 17 words under hold, the last one dropped
        hold8 = 1'b1;
        for (int i = 0; i < 17; i++) begin
            d = {8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0)};
            if (i < 16) push8(32'h100 + 32'(4*i), d);
            bus_write(32'h100 + 32'(4*i), d, 1'b0);
        end
        bus_read(CTRL, r8, r16);
        check("status_full_ovf", r8, 32'h0000_1003);
        pt8.delete();
        hold8 = 1'b0;
        wait_q8(1000, "ovf_drained");
        check("ovf_beats", 32'(pt8.size()), 32'd64);
        for (int i = 0; i < 63; i++) check("ovf_gap", 32'(pt8[i+1] - pt8[i]), 32'd4);
        tick(2);
        bus_read(CTRL, r8, r16);
        check("status_ovf_sticky", r8, 32'h0000_0007);

        // hold for 10 cycles right after the second beat
        pt8.delete();
        push8(32'h200, 32'hDEAD_BEEF);
        bus_write(32'h200, 32'hDEAD_BEEF, 1'b0);
        n = 0;
        while (pt8.size() < 2 && n < 50) begin tick(1); n++; end
        check("hold_two_beats", 32'(pt8.size()), 32'd2);
        hold8 = 1'b1;
        tick(10);
        hold8 = 1'b0;
        wait_q8(100, "hold_done");
        check("hold_gap", 32'(pt8[2] - pt8[1]), 32'd14);
        check("hold_gap_after", 32'(pt8[3] - pt8[2]), 32'd4);

        // end with two words queued
        hold8 = 1'b1;
        push8(32'h300, 32'hA1B2_C3D4);
        bus_write(32'h300, 32'hA1B2_C3D4, 1'b0);
        push8(32'h304, 32'h5566_7788);
        bus_write(32'h304, 32'h5566_7788, 1'b0);
        bus_write(CTRL, 32'h2, 1'b0);
        bus_read(CTRL, r8, r16);
        check("drain_status", r8, 32'h0000_0203);
        pt8.delete();
        fall_cyc = -1;
        hold8 = 1'b0;
        wait_q8(200, "drain_done");
        tick(5);
        check("drain_beats", 32'(pt8.size()), 32'd8);
        check("drain_fall", 32'(fall_cyc - pt8[7]), 32'd2);
        check("drain_dl", {31'd0, dl8}, 32'd0);
        bus_read(CTRL, r8, r16);
        check("status_idle_ovf", r8, 32'h0000_0006);

        // new session (both bits: start wins), address wrap and checksum
        bus_write(CTRL, 32'h3, 1'b0);
        bus_read(CTRL, r8, r16);
        check("restart_status", r8, 32'h0000_0005);
        push8(32'h01FF_FFFE, 32'h0102_0304);
        bus_write(32'h01FF_FFFE, 32'h0102_0304, 1'b0);
        bus_write(CTRL, 32'h2, 1'b0);
        wait_q8(100, "wrap_done");
        n = 0;
        while (dl8 !== 1'b0 && n < 20) begin tick(1); n++; end
        check("final_dl", {31'd0, dl8}, 32'd0);
        bus_read(CTRL + 32'd4, r8, r16);
`ifdef JTFRAME_POCKET_CHKSUM_EN
        check("chksum", r8, 32'h0000_000A);
`else
        check("chksum_absent", r8, 32'h0000_0000);
`endif

        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
